// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: memory-stage controller splitting each 32-bit LDR/STR into two 16-bit SRAM transfers plus wait states.
module mem_sram_ctrl #(
  parameter int unsigned ADDR_BASE     = 1024,
  parameter int unsigned SRAM_AW       = 18,
  parameter int unsigned ACCESS_CYCLES = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);
  localparam int unsigned WW = SRAM_AW - 1;
  localparam logic [3:0] WAIT_LD = 4'(ACCESS_CYCLES - 4);
  typedef enum logic [2:0] {IDLE, LO, HI, WAIT, DONE} state_t;
  state_t            state_q;
  logic [WW-1:0]     widx_d, widx_q;
  logic [15:0]       wdata_hi_q, dq_q;
  logic              is_wr_q, oe_q, we_n_q;
  logic [3:0]        cnt_q;
  logic [31:0]       read_data_q;
  logic [SRAM_AW-1:0] addr_q;
  assign widx_d     = WW'((address - 32'(ADDR_BASE)) >> 2);
  assign ready      = rst_n && (state_q == DONE || (state_q == IDLE && !rd_en && !wr_en));
  assign read_data  = read_data_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_q;
  assign sram_dq_oe = oe_q;
  assign sram_we_n  = we_n_q;
  // Bus outputs are registered one state ahead so they line up with LO/HI.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      widx_q      <= '0;
      wdata_hi_q  <= '0;
      is_wr_q     <= 1'b0;
      cnt_q       <= '0;
      read_data_q <= '0;
      addr_q      <= '0;
      dq_q        <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (wr_en || rd_en) begin
          is_wr_q <= wr_en;
          widx_q  <= widx_d;
          addr_q  <= {widx_d, 1'b0};
          oe_q    <= wr_en;
          we_n_q  <= !wr_en;
          if (wr_en) begin
            wdata_hi_q <= write_data[31:16];
            dq_q       <= write_data[15:0];
          end
          state_q <= LO;
        end
        LO: begin
          if (!is_wr_q) read_data_q[15:0] <= sram_dq_i;
          if (is_wr_q) dq_q <= wdata_hi_q;
          addr_q  <= {widx_q, 1'b1};
          state_q <= HI;
        end
        HI: begin
          if (!is_wr_q) read_data_q[31:16] <= sram_dq_i;
          oe_q    <= 1'b0;
          we_n_q  <= 1'b1;
          cnt_q   <= WAIT_LD;
          state_q <= (ACCESS_CYCLES == 4) ? DONE : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: directed checks of mem_sram_ctrl against a small SRAM model and hand-computed values.
module tb_mem_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_dq_oe, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic [15:0] mem [256];
  logic        rd4, ready4, oe4, we4, rd15, ready15, oe15, we15;
  logic [31:0] rdat4, rdat15;
  logic [17:0] sa4, sa15;
  logic [15:0] dq4, dq15;
  logic [31:0] zero32 = '0;
  logic [15:0] zero16 = '0;
  logic        zero1 = 1'b0;
  int          total = 0, bad = 0, lat;
  logic        rdy0;
  logic [17:0] rec_addr [2];
  logic [15:0] rec_dq [2];
  logic        rec_we [2], rec_oe [2];

  always #5 clk = ~clk;

  mem_sram_ctrl dut (.clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n));
  mem_sram_ctrl #(.ACCESS_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .rd_en(rd4), .wr_en(zero1),
    .address(zero32), .write_data(zero32), .read_data(rdat4), .ready(ready4), .sram_addr(sa4),
    .sram_dq_o(dq4), .sram_dq_i(zero16), .sram_dq_oe(oe4), .sram_we_n(we4));
  mem_sram_ctrl #(.ACCESS_CYCLES(15)) dut15 (.clk(clk), .rst_n(rst_n), .rd_en(rd15), .wr_en(zero1),
    .address(zero32), .write_data(zero32), .read_data(rdat15), .ready(ready15), .sram_addr(sa15),
    .sram_dq_o(dq15), .sram_dq_i(zero16), .sram_dq_oe(oe15), .sram_we_n(we15));

  assign sram_dq_i = mem[sram_addr[7:0]];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request at a negedge and returns at the negedge where ready rises.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input bit hold);
    int n;
    rd_en = r; wr_en = w; address = a; write_data = d;
    #1 rdy0 = ready;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= 2) begin
        rec_addr[n-1] = sram_addr; rec_dq[n-1] = sram_dq_o;
        rec_we[n-1] = sram_we_n; rec_oe[n-1] = sram_dq_oe;
      end
      if (!hold && n == 1) begin
        rd_en = 0; wr_en = 0; address = $urandom; write_data = $urandom;
      end
    end while (!ready && n < 40);
    lat = n;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 0; rd_en = 0; wr_en = 0; address = 0; write_data = 0; rd4 = 0; rd15 = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_oe", 32'(sram_dq_oe), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_rdata", read_data, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_ready", 32'(ready), 1);

    access(0, 1, 1032, 32'hDEADBEEF, 0);
    chk("wr_rdy0", 32'(rdy0), 0);
    chk("wr_lat", lat, 5);
    chk("wr_lo_addr", 32'(rec_addr[0]), 4);
    chk("wr_lo_dq", 32'(rec_dq[0]), 32'hBEEF);
    chk("wr_lo_we", 32'(rec_we[0]), 0);
    chk("wr_lo_oe", 32'(rec_oe[0]), 1);
    chk("wr_hi_addr", 32'(rec_addr[1]), 5);
    chk("wr_hi_dq", 32'(rec_dq[1]), 32'hDEAD);
    chk("wr_hi_we", 32'(rec_we[1]), 0);
    chk("wr_done_we", 32'(sram_we_n), 1);
    chk("wr_rdata_kept", read_data, 0);
    @(negedge clk);
    chk("wr_idle_ready", 32'(ready), 1);

    access(1, 0, 1032, 0, 0);
    chk("rd_lat", lat, 5);
    chk("rd_addr0", 32'(rec_addr[0]), 4);
    chk("rd_addr1", 32'(rec_addr[1]), 5);
    chk("rd_we", {rec_we[0], rec_we[1]}, 2'b11);
    chk("rd_oe", {rec_oe[0], rec_oe[1]}, 2'b00);
    chk("rd_data", read_data, 32'hDEADBEEF);
    @(negedge clk);

    access(1, 0, 1035, 0, 0);
    chk("unal_addr0", 32'(rec_addr[0]), 4);
    chk("unal_addr1", 32'(rec_addr[1]), 5);
    chk("unal_data", read_data, 32'hDEADBEEF);
    @(negedge clk);

    access(0, 1, 1023, 32'hCAFEF00D, 0);
    chk("wrap_addr0", 32'(rec_addr[0]), 32'h3FFFE);
    chk("wrap_addr1", 32'(rec_addr[1]), 32'h3FFFF);
    chk("wrap_we", {rec_we[0], rec_we[1]}, 2'b00);
    @(negedge clk);
    access(1, 0, 1023, 0, 0);
    chk("wrap_rdata", read_data, 32'hCAFEF00D);
    @(negedge clk);

    access(1, 1, 1040, 32'h12345678, 0);
    chk("both_we", {rec_we[0], rec_we[1]}, 2'b00);
    chk("both_addr0", 32'(rec_addr[0]), 8);
    chk("both_dq", {rec_dq[1], rec_dq[0]}, 32'h12345678);
    chk("both_rdata_kept", read_data, 32'hCAFEF00D);
    @(negedge clk);
    access(1, 0, 1040, 0, 0);
    chk("both_readback", read_data, 32'h12345678);
    @(negedge clk);

    access(1, 0, 1032, 0, 1);
    chk("b2b_lat", lat, 5);
    chk("b2b_data1", read_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(ready), 0);
    chk("b2b_idle_addr", 32'(sram_addr), 5);
    chk("b2b_idle_we", 32'(sram_we_n), 1);
    @(negedge clk);
    chk("b2b_lo_addr", 32'(sram_addr), 4);
    rd_en = 0;
    lat = 1;
    while (!ready && lat < 40) begin @(negedge clk); lat++; end
    chk("b2b_lat2", lat, 5);
    chk("b2b_data2", read_data, 32'hDEADBEEF);
    @(negedge clk);

    wr_en = 1; address = 1048; write_data = 32'hAAAA5555;
    @(negedge clk);
    wr_en = 0;
    @(negedge clk);
    chk("rstw_hi_we", 32'(sram_we_n), 0);
    chk("rstw_hi_addr", 32'(sram_addr), 13);
    rst_n = 0;
    #1 chk("rstw_ready_low", 32'(ready), 0);
    @(negedge clk);
    chk("rstw_we", 32'(sram_we_n), 1);
    chk("rstw_oe", 32'(sram_dq_oe), 0);
    chk("rstw_addr", 32'(sram_addr), 0);
    chk("rstw_rdata", read_data, 0);
    chk("rstw_ready", 32'(ready), 0);
    rst_n = 1;
    @(negedge clk);
    chk("rstw_rel_ready", 32'(ready), 1);
    chk("rstw_rel_we", 32'(sram_we_n), 1);

    rd4 = 1;
    #1 chk("ac4_rdy0", 32'(ready4), 0);
    lat = 0;
    do begin @(negedge clk); lat++; rd4 = 0; end while (!ready4 && lat < 40);
    chk("ac4_lat", lat, 3);
    @(negedge clk);
    rd15 = 1;
    #1 chk("ac15_rdy0", 32'(ready15), 0);
    lat = 0;
    do begin @(negedge clk); lat++; rd15 = 0; end while (!ready15 && lat < 40);
    chk("ac15_lat", lat, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end
endmodule
